// File: rtl/alu_rr_scheduler_if.sv
// Request / response / ALU bundle for alu_rr_scheduler.
// master = requesters, response consumer and the ALU in the parent.
// slave  = the scheduler itself.
// Optional macro ALU_RR_SCHEDULER_LOCK_EN adds the req_lock signal.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready are both 1; the sender holds its payload stable while
// valid=1 and the transfer has not yet happened.
interface alu_rr_scheduler_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_y;
  logic              rsp_carry;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_sel;
  logic [DATA_W-1:0] alu_y;
  logic              alu_carry;
`ifdef ALU_RR_SCHEDULER_LOCK_EN
  logic [1:0]        req_lock;

  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
    output rsp_ready, alu_y, alu_carry, req_lock,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_carry,
    input  alu_a, alu_b, alu_sel
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
    input  rsp_ready, alu_y, alu_carry, req_lock,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_carry,
    output alu_a, alu_b, alu_sel
  );
`else
  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
    output rsp_ready, alu_y, alu_carry,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_carry,
    input  alu_a, alu_b, alu_sel
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
    input  rsp_ready, alu_y, alu_carry,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_carry,
    output alu_a, alu_b, alu_sel
  );
`endif
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one external combinational ALU between two
// requesters. Flow per op: IDLE (grant + latch operands) -> EXEC (ALU
// settles, result captured) -> RESP (hold result until consumed).
// Optional macro ALU_RR_SCHEDULER_LOCK_EN: a requester asserting req_lock at
// its response handshake keeps priority for the next arbitration.
// o_dbg_state exposes the FSM state for observation.
module alu_rr_scheduler #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  alu_rr_scheduler_if.slave bus,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_ptr;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [OP_W-1:0]   r_alu_sel;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_y;
  logic              r_rsp_carry;
  logic [1:0]        w_grant;
  logic              w_grant_id;
  logic              w_prio;
`ifdef ALU_RR_SCHEDULER_LOCK_EN
  // Lock owner is r_rsp_id: it cannot change before the next grant,
  // and the next grant clears the lock.
  logic              r_lock;
`endif

  // Arbitration: only in IDLE and out of reset; ptr (or lock owner) breaks ties
  always_comb begin
    w_prio = r_ptr;
`ifdef ALU_RR_SCHEDULER_LOCK_EN
    if (r_lock) w_prio = r_rsp_id;
`endif
    w_grant = 2'b00;
    if (r_state == ST_IDLE && !rst) begin
      case (bus.req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = w_prio ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
    w_grant_id = w_grant[1];
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (|w_grant) w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: if (bus.rsp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Datapath: operand latch on grant, result capture in EXEC, pointer update on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_y     <= '0;
      r_rsp_carry <= 1'b0;
`ifdef ALU_RR_SCHEDULER_LOCK_EN
      r_lock      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_alu_a   <= w_grant_id ? bus.req1_a  : bus.req0_a;
            r_alu_b   <= w_grant_id ? bus.req1_b  : bus.req0_b;
            r_alu_sel <= w_grant_id ? bus.req1_op : bus.req0_op;
            r_rsp_id  <= w_grant_id;
          end
`ifdef ALU_RR_SCHEDULER_LOCK_EN
          // Lock is consumed by any grant, or dropped when its owner is idle
          if (r_lock && ((|w_grant) || !bus.req_valid[r_rsp_id])) r_lock <= 1'b0;
`endif
        end
        ST_EXEC: begin
          r_rsp_y     <= bus.alu_y;
          r_rsp_carry <= bus.alu_carry;
          r_rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
`ifdef ALU_RR_SCHEDULER_LOCK_EN
            if (bus.req_lock[r_rsp_id]) r_lock <= 1'b1;
            else                        r_ptr  <= ~r_rsp_id;
`else
            r_ptr <= ~r_rsp_id;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_y     = r_rsp_y;
  assign bus.rsp_carry = r_rsp_carry;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_sel   = r_alu_sel;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one combinational 4-bit ALU (ports a, b, sel, y, carry; ops ADD/SUB/AND/OR/XOR/NOT/INC/DEC on sel 000..111) between two requesters.
- Round-robin arbitration; per-requester valid/ready request handshake; one shared response channel tagged with the requester ID.
- Drives the ALU from registered operands and captures y/carry into a result register.
- Sits between the requesters and the ALU instance, which lives in the parent and connects through the alu_* ports.

Parameters:
- DATA_W, 4, operand/result width; must match the ALU.
- OP_W, 3, ALU op-select width; must match the ALU sel.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  bit i = requester i has an op pending.
- req_ready  output  2  bit i = requester i's op accepted this cycle (combinational, one-hot or zero).
- req0_a, req0_b  input  DATA_W  requester 0 operands.
- req0_op  input  OP_W  requester 0 ALU select.
- req1_a, req1_b  input  DATA_W  requester 1 operands.
- req1_op  input  OP_W  requester 1 ALU select.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  response consumer accepts the result.
- rsp_id  output  1  requester that issued the result.
- rsp_y  output  DATA_W  ALU result.
- rsp_carry  output  1  ALU carry, captured verbatim.
- alu_a, alu_b  output  DATA_W  to ALU a, b (registered).
- alu_sel  output  OP_W  to ALU sel (registered).
- alu_y  input  DATA_W  from ALU y.
- alu_carry  input  1  from ALU carry.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high.
- Reset values: state=IDLE; alu_a/alu_b/alu_sel=0; rsp_valid=0, rsp_id=0, rsp_y=0, rsp_carry=0; priority pointer ptr=0 (requester 0 favoured).
- req_ready is 0 outside IDLE and 0 while rst=1.
- IDLE:
  - No req_valid: stay in IDLE.
  - Exactly one req_valid: grant that requester.
  - Both valid: grant requester ptr.
  - On grant: req_ready[g]=1 in the same cycle; latch that requester's a/b/op into alu_a/alu_b/alu_sel; latch g into rsp_id; go to EXEC.
- EXEC (1 cycle): ALU settles from the registered inputs. Capture alu_y into rsp_y and alu_carry into rsp_carry; set rsp_valid=1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_y and rsp_carry stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid=0, ptr = ~rsp_id, go to IDLE.
  - No new request is accepted in RESP.
- Latency and throughput:
  - Acceptance edge at cycle N; rsp_valid high from cycle N+2.
  - With rsp_ready tied high: one op every 3 cycles (IDLE, EXEC, RESP).
- alu_a/alu_b/alu_sel hold their last latched values after completion; no glitching to 0.
- Requesters must keep a/b/op stable while req_valid=1 and unaccepted. The scheduler samples them only on the accept cycle.
- Deasserting req_valid before acceptance withdraws the request; the scheduler does not record it.
- Fairness: once both requesters are continuously valid, grants strictly alternate.
- Reset mid-operation (EXEC or RESP): return to IDLE with reset values. Any in-flight result is discarded and no rsp_valid is produced.
- Arithmetic: no width manipulation. Result and carry are exactly the ALU's outputs for the latched operands.

Optional Feature:
- Macro: ALU_RR_SCHEDULER_LOCK_EN.
- Defined:
  - Adds port req_lock  input  2.
  - At the rsp handshake, if req_lock[rsp_id]=1, ptr is left unchanged and the lock flag is set.
  - While the lock flag is set, requester rsp_id wins the next IDLE arbitration whenever its req_valid=1, even if the other requester is valid.
  - The lock flag clears on the first grant after it was set. It also clears if the locked requester is idle in IDLE, letting the other requester be granted.
  - rst clears the lock flag.
- Not defined: no req_lock port; pure round-robin as above.

Test Plan:
- Single ADD: rsp_ready=1; requester 0 issues a=5, b=3, op=000 → req_ready=2'b01 in the accept cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_y=8, rsp_carry=0.
- Contention: both valid from reset; r0 ADD 5+3, r1 XOR 5^3 → first response id=0 y=8, second id=1 y=6, grants alternate over 6 back-to-back ops.
- Overflow carry: r1 ADD a=15, b=1 → rsp_y=0, rsp_carry=1, rsp_id=1.
- Backpressure: hold rsp_ready=0 for 3 cycles with r0 also valid → rsp fields stable, req_ready=0 throughout; release → handshake, then r0 accepted next IDLE cycle.
- Reset mid-EXEC: assert rst for 1 cycle in EXEC → no rsp_valid; alu_a/alu_b/alu_sel=0, ptr=0; a new r1 request is then accepted normally.
- (LOCK_EN build) r0 with req_lock=1, both valid, 3 ops → r0, r0, then after r0 drops lock: r1.
